keypad_scan_ctrl: RTL

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//   Scans a 4x4 matrix keypad one row at a time and debounces presses and
//   releases. Each accepted press is offered exactly once on a valid/ready
//   interface. A press that arrives while an earlier event is still unconsumed
//   is dropped, and the sticky overrun flag records the loss.
//
// Ports
//   clk_raw    in   50 MHz clock, all state changes on its rising edge
//   reset_n    in   asynchronous active-low reset
//   row[3:0]   out  active-low row drive, exactly one bit low
//   col[3:0]   in   active-low column sense, 4'b1111 when no key is down
//   key_code   out  {row_idx, col_idx} of the accepted key
//   key_valid  out  key_code holds an unconsumed event
//   key_ready  in   consumer takes the event when key_valid && key_ready
//   key_held   out  accepted key is still physically pressed
//   overrun    out  sticky, an event was dropped (cleared only by reset)
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 1000,  // clocks per row before the columns are sampled
  parameter int DEB_CYCLES = 50000  // stable clocks to accept a press or a release
) (
  input  logic       clk_raw,
  input  logic       reset_n,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int DIV_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    PRESS,
    HOLD,
    REL_DEB
  } state_e;

  state_e           state_q;
  logic [1:0]       row_idx_q;
  logic [1:0]       col_idx_q;
  logic [3:0]       row_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;
  logic             overrun_q;

  // One-cold row drive for a given row index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Lowest-numbered low column wins when several keys in a row are down.
  function automatic logic [1:0] lowest_low(input logic [3:0] c);
    if (!c[0]) return 2'd0;
    if (!c[1]) return 2'd1;
    if (!c[2]) return 2'd2;
    return 2'd3;
  endfunction

  // Only the column latched at detection time is tracked; any other key in the
  // matrix is ignored until the tracked key has been released and debounced.
  // col is taken without a synchronizer: a metastable read only restarts or
  // extends a debounce window, it cannot create an event by itself.
  logic key_down;
  assign key_down = ~col[col_idx_q];

  // NOTE: every state register is reset (there is no memory array here) and
  // every sequential update uses non-blocking assignment, so the order of the
  // statements below does not change what is sampled on an edge.
  always_ff @(posedge clk_raw or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SCAN;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      div_cnt_q   <= '0;
      deb_cnt_q   <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // Handshake consumes the event; PRESS below may reload it on the same edge.
      if (key_valid_q && key_ready) key_valid_q <= 1'b0;

      case (state_q)
        SCAN: begin
          if (div_cnt_q == DIV_MAX) begin
            div_cnt_q <= '0;
            if (col == 4'b1111) begin
              row_idx_q <= row_idx_q + 2'd1;
              row_q     <= row_drive(row_idx_q + 2'd1);
            end else begin
              col_idx_q <= lowest_low(col);
              deb_cnt_q <= '0;
              state_q   <= DEBOUNCE;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (!key_down) begin
            // Bounce or glitch: abandon silently and move on to the next row.
            deb_cnt_q <= '0;
            div_cnt_q <= '0;
            row_idx_q <= row_idx_q + 2'd1;
            row_q     <= row_drive(row_idx_q + 2'd1);
            state_q   <= SCAN;
          end else if (deb_cnt_q == DEB_MAX) begin
            state_q <= PRESS;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end

        PRESS: begin
          if (!key_valid_q || key_ready) begin
            key_code_q  <= {row_idx_q, col_idx_q};
            key_valid_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
          key_held_q <= 1'b1;
          state_q    <= HOLD;
        end

        HOLD: begin
          if (!key_down) begin
            deb_cnt_q <= '0;
            state_q   <= REL_DEB;
          end
        end

        REL_DEB: begin
          if (key_down) begin
            state_q <= HOLD;
          end else if (deb_cnt_q == DEB_MAX) begin
            div_cnt_q  <= '0;
            row_idx_q  <= row_idx_q + 2'd1;
            row_q      <= row_drive(row_idx_q + 2'd1);
            key_held_q <= 1'b0;
            state_q    <= SCAN;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end

        default: state_q <= SCAN;
      endcase
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overrun   = overrun_q;

endmodule
